univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operation and a counted
// auto-shift burst controller.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; en applies one op per mode, start launches a burst
// SHIFT | burst running; one step of the latched mode per edge
// DONE  | one-cycle completion pulse, register held
module univ_shift_reg #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic [2:0]       mode,
   input  logic             en,
   input  logic             sin,
   input  logic             start,
   input  logic [CNT_W-1:0] cnt,
   output logic [WIDTH-1:0] out,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_LOAD = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [2:0]       r_mode;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_out;
   logic             r_sout;
   logic             r_busy;
   logic             r_done;

   logic [2:0]       w_op;
   logic [WIDTH-1:0] w_next;
   logic             w_sout_next;
   logic             w_sout_upd;
   logic             w_burst_mode;

   // Only the movement modes make sense as a counted burst.
   assign w_burst_mode = (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROL) ||
                         (mode == M_ROR) || (mode == M_ASR);

   // A running burst uses its latched mode; otherwise the live mode input.
   assign w_op = (r_state == SHIFT) ? r_mode : mode;

   // Next register value and shifted-out bit for the selected operation.
   always_comb begin
      w_next      = r_out;
      w_sout_next = r_sout;
      w_sout_upd  = 1'b0;
      case (w_op)
         M_HOLD: w_next = r_out;
         M_SHL: begin
            w_next      = {r_out[WIDTH-2:0], sin};
            w_sout_next = r_out[WIDTH-1];
            w_sout_upd  = 1'b1;
         end
         M_SHR: begin
            w_next      = {sin, r_out[WIDTH-1:1]};
            w_sout_next = r_out[0];
            w_sout_upd  = 1'b1;
         end
         M_ROL: begin
            w_next      = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            w_sout_next = r_out[WIDTH-1];
            w_sout_upd  = 1'b1;
         end
         M_ROR: begin
            w_next      = {r_out[0], r_out[WIDTH-1:1]};
            w_sout_next = r_out[0];
            w_sout_upd  = 1'b1;
         end
         M_LOAD: w_next = in;
         M_ASR: begin
            w_next      = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
            w_sout_next = r_out[0];
            w_sout_upd  = 1'b1;
         end
         M_CLR: w_next = '0;
         default: w_next = r_out;
      endcase
   end

   // Burst FSM with the data register, step counter and registered flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_mode  <= M_HOLD;
         r_cnt   <= '0;
         r_out   <= '0;
         r_sout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && w_burst_mode) begin
                  r_mode <= mode;
                  r_cnt  <= cnt;
                  if (cnt != '0) begin
                     r_state <= SHIFT;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end else if (en) begin
                  r_out <= w_next;
                  if (w_sout_upd) r_sout <= w_sout_next;
               end
            end
            SHIFT: begin
               r_out <= w_next;
               if (w_sout_upd) r_sout <= w_sout_next;
               // Leave on the final step, so the counter never goes below zero.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = r_out;
   assign sout = r_sout;
   assign busy = r_busy;
   assign done = r_done;

endmodule
